// File: rtl/beam_delay_line.sv
// Multi-channel integer-sample delay line for delay-and-sum beamforming; per-channel delays are
// staged in shadow registers and committed on a sample boundary. Define DELAY_SUM_EN to add sum_valid/sum_out.
module beam_delay_line #(
  parameter int  NUM_CH    = 8,
  parameter int  DATA_W    = 19,
  parameter int  ADDR_W    = 5,
  parameter int  MAX_DELAY = 31,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] pcm_in,
  input  logic                     cfg_wr,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [ADDR_W-1:0]        cfg_delay,
  input  logic                     cfg_commit,
  output logic                     cfg_busy,
  output logic                     cfg_err,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] pcm_out
`ifdef DELAY_SUM_EN
  ,
  output logic                     sum_valid,
  output logic signed [DATA_W+CH_W-1:0] sum_out
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, PEND} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   shadow_q [NUM_CH];
  logic [ADDR_W-1:0]   shadow_d [NUM_CH];
  logic [ADDR_W-1:0]   active_q [NUM_CH];
  logic [ADDR_W-1:0]   active_d [NUM_CH];
  logic                err_q, err_d;
  logic                apply;

  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W:0]     fill_q, fill_inc;
  logic                s1_valid_q;
  logic [ADDR_W-1:0]   rd_addr_q [NUM_CH];
  logic [NUM_CH-1:0]   blank_q;
  logic                out_valid_q;
  logic [NUM_CH*DATA_W-1:0] pcm_out_q;
  logic [DATA_W-1:0]   mem [NUM_CH][DEPTH];

  logic                ch_ok, dly_ok;
  logic [ADDR_W-1:0]   dly_wr;

  // Range checks only exist when the port width can actually express an illegal value.
  if (NUM_CH < (2 ** CH_W)) begin : g_ch_range
    assign ch_ok = (cfg_ch < CH_W'(NUM_CH));
  end else begin : g_ch_full
    assign ch_ok = 1'b1;
  end

  if (MAX_DELAY < DEPTH - 1) begin : g_dly_range
    assign dly_ok = (cfg_delay <= ADDR_W'(MAX_DELAY));
  end else begin : g_dly_full
    assign dly_ok = 1'b1;
  end

  assign dly_wr   = dly_ok ? cfg_delay : ADDR_W'(MAX_DELAY);
  assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + (ADDR_W+1)'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    apply    = 1'b0;

    if (cfg_wr) begin
      if (ch_ok) shadow_d[cfg_ch] = dly_wr;
      if (!ch_ok || !dly_ok) err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cfg_commit) begin
          if (in_valid) apply = 1'b1;
          else          state_d = PEND;
        end
      end
      PEND: begin
        if (in_valid) begin
          apply   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Same-cycle shadow writes are part of the commit, hence shadow_d rather than shadow_q.
    if (apply) active_d = shadow_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q     <= IDLE;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      s1_valid_q  <= 1'b0;
      blank_q     <= '0;
      out_valid_q <= 1'b0;
      pcm_out_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k]  <= '0;
        active_q[k]  <= '0;
        rd_addr_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      err_q       <= err_d;
      s1_valid_q  <= in_valid;
      out_valid_q <= s1_valid_q;

      if (in_valid) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        fill_q   <= fill_inc;
        for (int k = 0; k < NUM_CH; k++) begin
          rd_addr_q[k] <= wr_ptr_q - active_d[k];
          blank_q[k]   <= ({1'b0, active_d[k]} >= fill_inc);
        end
      end

      // The read happens one edge after the write, so delay 0 sees this sample without a bypass mux.
      if (s1_valid_q) begin
        for (int k = 0; k < NUM_CH; k++) begin
          pcm_out_q[k*DATA_W +: DATA_W] <= blank_q[k] ? '0 : mem[k][rd_addr_q[k]];
        end
      end
    end
  end

  // NOTE: sample buffers are deliberately not reset; the fill counter masks unwritten entries.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mem[k][wr_ptr_q] <= pcm_in[k*DATA_W +: DATA_W];
      end
    end
  end

  assign cfg_busy  = (state_q == PEND);
  assign cfg_err   = err_q;
  assign out_valid = out_valid_q;
  assign pcm_out   = pcm_out_q;

`ifdef DELAY_SUM_EN
  localparam int SUM_W = DATA_W + CH_W;

  logic signed [SUM_W-1:0] sum_d, sum_q;
  logic                    sum_valid_q;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_d = sum_d + {{CH_W{pcm_out_q[k*DATA_W+DATA_W-1]}}, pcm_out_q[k*DATA_W +: DATA_W]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= out_valid_q;
      if (out_valid_q) sum_q <= sum_d;
    end
  end

  assign sum_valid = sum_valid_q;
  assign sum_out   = sum_q;
`endif

endmodule

// File: tb/tb_beam_delay_line.sv
// Bench for beam_delay_line: table-driven sample vectors checked through a latency-aware scoreboard,
// plus hand sequences for commit timing, warm-up, wrap and config errors (second instance with 6 ch / max delay 20).
module tb_beam_delay_line;
  localparam int NUM_CH = 8, DATA_W = 19, ADDR_W = 5, MAX_DELAY = 31, CH_W = 3;
  localparam int NB = 6, MAXB = 20;
  localparam int W = NUM_CH * DATA_W, WB = NB * DATA_W;

  typedef struct {
    logic [W-1:0]      pcm;
    logic [W-1:0]      exp;
    logic              wr;
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] dly;
    logic              commit;
  } vec_t;

  typedef struct {
    logic [W-1:0] exp;
    int           t;
  } sb_t;

  logic              clk, rst, in_valid, cfg_wr, cfg_commit;
  logic [W-1:0]      pcm_in;
  logic [CH_W-1:0]   cfg_ch;
  logic [ADDR_W-1:0] cfg_delay;
  logic              cfg_busy, cfg_err, out_valid;
  logic [W-1:0]      pcm_out;
  logic              cfg_busy_b, cfg_err_b, out_valid_b;
  logic [WB-1:0]     pcm_out_b;
`ifdef DELAY_SUM_EN
  logic                         sum_valid, sum_valid_b;
  logic signed [DATA_W+CH_W-1:0] sum_out, sum_out_b;
`endif

  int   n_vec = 0, n_miss = 0, cyc = 0;
  sb_t  sbq[$];
  vec_t tbl[$];

  beam_delay_line #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_DELAY(MAX_DELAY)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pcm_in(pcm_in),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err), .out_valid(out_valid), .pcm_out(pcm_out)
`ifdef DELAY_SUM_EN
    , .sum_valid(sum_valid), .sum_out(sum_out)
`endif
  );

  beam_delay_line #(.NUM_CH(NB), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_DELAY(MAXB)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pcm_in(pcm_in[WB-1:0]),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy_b), .cfg_err(cfg_err_b), .out_valid(out_valid_b), .pcm_out(pcm_out_b)
`ifdef DELAY_SUM_EN
    , .sum_valid(sum_valid_b), .sum_out(sum_out_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each strobe must produce exactly one output two clocks later.
  always @(negedge clk) begin
    sb_t e;
    if (rst && out_valid) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_miss++;
        $display("FAIL spurious_out_valid: out_valid at cycle %0d with no sample pending", cyc);
      end else begin
        e = sbq.pop_front();
        if (pcm_out !== e.exp || cyc != e.t + 2) begin
          n_miss++;
          $display("FAIL sample_out: got %0h at cycle %0d, expected %0h at cycle %0d",
                   pcm_out, cyc, e.exp, e.t + 2);
        end
      end
    end
  end

  function automatic logic [W-1:0] set_ch(input logic [W-1:0] x, input int k, input int val);
    logic [W-1:0] r;
    r = x;
    r[k*DATA_W +: DATA_W] = DATA_W'(val);
    return r;
  endfunction

  function automatic logic [W-1:0] splat(input int val);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) r = set_ch(r, k, val);
    return r;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] pcm, input logic [W-1:0] exp);
    vec_t v;
    v.pcm = pcm; v.exp = exp; v.wr = 1'b0; v.ch = '0; v.dly = '0; v.commit = 1'b0;
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; pcm_in = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_delay = '0; cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst_pcm_out", pcm_out, '0);
    idle_inputs();
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic cfg_write(input int ch, input int dly);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_delay = ADDR_W'(dly);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic send(input vec_t v);
    sb_t e;
    @(negedge clk);
    in_valid = 1'b1; pcm_in = v.pcm;
    cfg_wr = v.wr; cfg_ch = v.ch; cfg_delay = v.dly; cfg_commit = v.commit;
    e.exp = v.exp; e.t = cyc;
    sbq.push_back(e);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t v;
    logic [W-1:0] x;
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_pcm_out", pcm_out, '0);
    check("rst_cfg_busy", W'(cfg_busy), '0);
    check("rst_cfg_err", W'(cfg_err), '0);
    rst = 1'b1;

    // All delays zero: output mirrors input, including negative samples.
    tbl.delete();
    for (int i = 0; i < 4; i++) begin
      x = '0;
      for (int k = 0; k < NUM_CH; k++) x = set_ch(x, k, (i == 3) ? -(256 + k) : 256 + k + 32 * i);
      tbl.push_back(mk(x, x));
    end
    for (int i = 0; i < tbl.size(); i++) send(tbl[i]);

    // Staggered delays 0..7 with warm-up zeros; commit issued twice while pending.
    do_reset();
    for (int k = 0; k < NUM_CH; k++) cfg_write(k, k);
    @(negedge clk) cfg_commit = 1'b1;
    @(negedge clk) cfg_commit = 1'b0;
    check("commit_busy", W'(cfg_busy), W'(1));
    @(negedge clk) cfg_commit = 1'b1;
    @(negedge clk) cfg_commit = 1'b0;
    check("commit_busy_repeat", W'(cfg_busy), W'(1));
    tbl.delete();
    for (int n = 1; n <= 10; n++) begin
      x = '0;
      for (int k = 0; k < NUM_CH; k++) x = set_ch(x, k, (n > k) ? n - k : 0);
      tbl.push_back(mk(splat(n), x));
    end
    for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
    check("busy_cleared", W'(cfg_busy), '0);
    check("err_clean", W'(cfg_err), '0);

    // Wrap at delay 31 on ch0; write and commit land on the first strobe itself.
    do_reset();
    tbl.delete();
    for (int n = 1; n <= 40; n++) begin
      v = mk(splat(n), set_ch(splat(n), 0, (n <= 31) ? 0 : n - 31));
      if (n == 1) begin
        v.wr = 1'b1; v.ch = '0; v.dly = ADDR_W'(31); v.commit = 1'b1;
      end
      tbl.push_back(v);
    end
    send(tbl[0]);
    check("same_cycle_commit_busy", W'(cfg_busy), '0);
    for (int i = 1; i < tbl.size(); i++) send(tbl[i]);

    // Commit timing: active 2, shadow 5, commit two clocks before the strobe.
    v = mk(splat(41), set_ch(set_ch(splat(41), 0, 10), 1, 39));
    v.wr = 1'b1; v.ch = CH_W'(1); v.dly = ADDR_W'(2); v.commit = 1'b1;
    send(v);
    cfg_write(1, 5);
    send(mk(splat(42), set_ch(set_ch(splat(42), 0, 11), 1, 40)));
    @(negedge clk) cfg_commit = 1'b1;
    @(negedge clk) cfg_commit = 1'b0;
    check("pend_busy", W'(cfg_busy), W'(1));
    send(mk(splat(43), set_ch(set_ch(splat(43), 0, 12), 1, 38)));
    check("pend_applied", W'(cfg_busy), '0);

    // Config errors on the 6-channel, max-delay-20 instance.
    do_reset();
    cfg_write(7, 1);
    check("bad_ch_err_b", W'(cfg_err_b), W'(1));
    check("good_ch_err_a", W'(cfg_err), '0);
    do_reset();
    check("err_cleared_by_rst", W'(cfg_err_b), '0);
    cfg_write(3, 25);
    check("clamp_err_b", W'(cfg_err_b), W'(1));
    check("no_clamp_err_a", W'(cfg_err), '0);
    cfg_write(2, 0);
    check("err_sticky_b", W'(cfg_err_b), W'(1));
    @(negedge clk) cfg_commit = 1'b1;
    @(negedge clk) cfg_commit = 1'b0;
    tbl.delete();
    for (int n = 1; n <= 22; n++) tbl.push_back(mk(splat(n), set_ch(splat(n), 3, 0)));
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i]);
      if (i + 1 >= MAXB)
        check($sformatf("clamped_ch3_n%0d", i + 1), W'(pcm_out_b[3*DATA_W +: DATA_W]), W'(i + 1 - MAXB));
    end

`ifdef DELAY_SUM_EN
    begin
      sb_t e;
      logic signed [DATA_W+CH_W-1:0] m8;
      m8 = -8;
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; pcm_in = splat(-1);
      e.exp = splat(-1); e.t = cyc;
      sbq.push_back(e);
      @(negedge clk) idle_inputs();
      @(negedge clk) check("sum_valid_early", W'(sum_valid), '0);
      @(negedge clk) check("sum_valid_pulse", W'(sum_valid), W'(1));
      check("sum_out_m8", W'(sum_out), W'(m8));
    end
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_drained", W'(sbq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
